// File: rtl/bdf_ctrl_loader.sv
// Schedule-table loader for the BDF buffer controller: captures one iteration of
// toggle rows from the host, bursts them into the controller, then starts, tracks and stops the schedule.
module bdf_ctrl_loader #(
    parameter int NUM_BUFFS   = 12,
    parameter int CTRL_WIDTH  = NUM_BUFFS * 2,
    parameter int ITER_PERIOD = 48,
    parameter int START_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [CTRL_WIDTH-1:0] row_data,
    input  logic                  go,
    input  logic                  halt,
    input  logic                  clear,
    output logic                  load_ctrl,
    output logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  start_ctrl,
    output logic                  stop_ctrl,
    output logic                  busy,
    output logic                  running,
    output logic [15:0]           iter_count,
    output logic [2:0]            dbg_state_o
);

    localparam int PW = (ITER_PERIOD > 1) ? $clog2(ITER_PERIOD) : 1;
    localparam logic [PW-1:0] LAST = PW'(ITER_PERIOD - 1);
    localparam int GW = $clog2(START_GAP + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((START_GAP > 0) ? START_GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_FILL = 3'd0,
        S_FULL = 3'd1,
        S_LOAD = 3'd2,
        S_GAP  = 3'd3,
        S_RUN  = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         rd_nxt;
    logic [PW-1:0]         phase_q, phase_d;
    logic                  arm_q, arm_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [15:0]           iter_q, iter_d;
    logic                  wr_en;
    logic [CTRL_WIDTH-1:0] mem_q [ITER_PERIOD];

    logic                  load_q, load_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;
    logic                  busy_q, busy_d;
    logic                  run_q, run_d;

    assign rd_nxt = rd_ptr_q + PW'(1);

    // Valid/ready: a row transfers on any cycle where row_valid and row_ready are both high;
    // row_ready is a pure decode of the state register (high only in FILL).
    assign row_ready = (state_q == S_FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            phase_q  <= '0;
            arm_q    <= 1'b0;
            gap_q    <= '0;
            iter_q   <= '0;
            load_q   <= 1'b0;
            ctrl_q   <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            phase_q  <= phase_d;
            arm_q    <= arm_d;
            gap_q    <= gap_d;
            iter_q   <= iter_d;
            load_q   <= load_d;
            ctrl_q   <= ctrl_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            busy_q   <= busy_d;
            run_q    <= run_d;
        end
    end

    // Table storage is deliberately not reset; returning to FILL invalidates it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= row_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        phase_d  = phase_q;
        arm_d    = arm_q;
        gap_d    = gap_q;
        iter_d   = iter_q;
        wr_en    = 1'b0;
        case (state_q)
            S_FILL: begin
                // clear takes priority over a row offered in the same cycle
                if (clear) begin
                    wr_ptr_d = '0;
                end else if (row_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST) begin
                        state_d  = S_FULL;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PW'(1);
                    end
                end
            end
            S_FULL: begin
                if (clear) begin
                    state_d  = S_FILL;
                    wr_ptr_d = '0;
                end else if (go) begin
                    state_d  = S_LOAD;
                    rd_ptr_d = '0;
                    iter_d   = '0;
                end
            end
            S_LOAD: begin
                if (halt) begin
                    state_d = S_FULL;
                end else if (rd_ptr_q == LAST) begin
                    if (START_GAP == 0) begin
                        state_d = S_RUN;
                        arm_d   = 1'b1;
                        phase_d = '0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end else begin
                    rd_ptr_d = rd_nxt;
                end
            end
            S_GAP: begin
                if (halt) begin
                    state_d = S_FULL;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_RUN;
                    arm_d   = 1'b1;
                    phase_d = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_RUN: begin
                // arm_q marks the start-pulse cycle so that phase 0 begins on the cycle after it
                if (halt) begin
                    state_d = S_FULL;
                end else if (arm_q) begin
                    arm_d = 1'b0;
                end else if (phase_q == LAST) begin
                    phase_d = '0;
                    if (iter_q != 16'hFFFF) begin
                        iter_d = iter_q + 16'd1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        load_d  = 1'b0;
        ctrl_d  = '0;
        start_d = 1'b0;
        stop_d  = 1'b0;
        case (state_q)
            S_FULL: begin
                if (go && !clear) begin
                    load_d = 1'b1;
                    ctrl_d = mem_q[0];
                end
            end
            S_LOAD: begin
                if (!halt && rd_ptr_q != LAST) begin
                    load_d = 1'b1;
                    ctrl_d = mem_q[rd_nxt];
                end
                if (!halt && rd_ptr_q == LAST && START_GAP == 0) begin
                    start_d = 1'b1;
                end
            end
            S_GAP: begin
                if (!halt && gap_q == GAP_LAST) begin
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                stop_d = halt;
            end
            default: ;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_GAP) || (state_d == S_RUN);
        run_d  = (state_d == S_RUN);
    end

    assign load_ctrl   = load_q;
    assign ctrl_in     = ctrl_q;
    assign start_ctrl  = start_q;
    assign stop_ctrl   = stop_q;
    assign busy        = busy_q;
    assign running     = run_q;
    assign iter_count  = iter_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bdf_ctrl_loader.sv
// Bench for bdf_ctrl_loader: directed table fills and schedule runs, controller
// events checked against a cycle-stamped expected queue.
module tb_bdf_ctrl_loader;

    localparam int CW = 24;
    localparam int IP = 48;
    localparam int SG = 2;
    localparam int EW = CW + 3;

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_FULL = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          row_valid;
    logic          row_ready;
    logic [CW-1:0] row_data;
    logic          go;
    logic          halt;
    logic          clear;
    logic          load_ctrl;
    logic [CW-1:0] ctrl_in;
    logic          start_ctrl;
    logic          stop_ctrl;
    logic          busy;
    logic          running;
    logic [15:0]   iter_count;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_t_q[$];
    logic [CW-1:0] mdl[IP];

    bdf_ctrl_loader #(
        .NUM_BUFFS(12), .CTRL_WIDTH(CW), .ITER_PERIOD(IP), .START_GAP(SG)
    ) dut (
        .clk(clk), .rst(rst),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .go(go), .halt(halt), .clear(clear),
        .load_ctrl(load_ctrl), .ctrl_in(ctrl_in),
        .start_ctrl(start_ctrl), .stop_ctrl(stop_ctrl),
        .busy(busy), .running(running), .iter_count(iter_count),
        .dbg_state_o(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // scoreboard monitor: every controller event pops one cycle-stamped expectation
    always @(negedge clk) begin
        logic [EW-1:0] act;
        if (!rst) begin
            if (load_ctrl || start_ctrl || stop_ctrl) begin
                act = {load_ctrl, start_ctrl, stop_ctrl, ctrl_in};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", act, cyc);
                end else begin
                    chk("event", 32'(act), 32'(exp_q.pop_front()));
                    chk("event_cycle", cyc, exp_t_q.pop_front());
                end
            end else begin
                chk("ctrl_in_idle", 32'(ctrl_in), 32'd0);
            end
        end
    end

    // driver tasks
    task automatic fill_rows(input bit gaps, input logic [CW-1:0] base, input logic [CW-1:0] stride);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < IP && guard < 400) begin
            row_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            row_data  = base + stride * CW'(idx);
            chk("row_ready_fill", 32'(row_ready), 32'd1);
            acc = row_valid;
            if (acc) mdl[idx] = row_data;
            step();
            if (acc) idx++;
            guard++;
        end
        chk("fill_count", idx, IP);
        row_valid = 1'b1;
        row_data  = '1;
        repeat (4) begin
            chk("row_ready_full", 32'(row_ready), 32'd0);
            chk("state_full", 32'(dbg_state), 32'(S_FULL));
            step();
        end
        row_valid = 1'b0;
    endtask

    task automatic go_cycle(input int nrows, input bit with_start, output int t);
        t = cyc;
        for (int k = 0; k < nrows; k++) begin
            exp_q.push_back({3'b100, mdl[k]});
            exp_t_q.push_back(t + 1 + k);
        end
        if (with_start) begin
            exp_q.push_back({3'b010, {CW{1'b0}}});
            exp_t_q.push_back(t + IP + SG + 1);
        end
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic halt_run();
        exp_q.push_back({3'b001, {CW{1'b0}}});
        exp_t_q.push_back(cyc + 1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("stop_pulse", 32'(stop_ctrl), 32'd1);
        chk("halt_running", 32'(running), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_state", 32'(dbg_state), 32'(S_FULL));
    endtask

    initial begin
        int t;
        int s;
        rst = 1'b1; row_valid = 1'b0; row_data = '0; go = 1'b0; halt = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_ready", 32'(row_ready), 32'd1);
        chk("rst_load", 32'(load_ctrl), 32'd0);
        chk("rst_ctrl_in", 32'(ctrl_in), 32'd0);
        chk("rst_start", 32'(start_ctrl), 32'd0);
        chk("rst_stop", 32'(stop_ctrl), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_iter", 32'(iter_count), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_FILL));
        rst = 1'b0;
        step();

        // go and halt in FILL are ignored
        go_cycle(0, 1'b0, t);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("fill_go_ignored_busy", 32'(busy), 32'd0);
        chk("fill_go_ignored_state", 32'(dbg_state), 32'(S_FILL));

        // fill with row_data = k, then halt in FULL is ignored
        fill_rows(1'b0, '0, 24'd1);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("full_halt_ignored", 32'(dbg_state), 32'(S_FULL));

        // load, start, run 150 cycles, halt
        go_cycle(IP, 1'b1, t);
        chk("busy_after_go", 32'(busy), 32'd1);
        s = t + IP + SG + 1;
        wait_until(s - 1);
        chk("running_before_start", 32'(running), 32'd0);
        wait_until(s);
        chk("start_pulse", 32'(start_ctrl), 32'd1);
        chk("running_at_start", 32'(running), 32'd1);
        wait_until(s + 1);
        chk("start_one_cycle", 32'(start_ctrl), 32'd0);
        wait_until(s + 48);
        chk("iter_before_first_wrap", 32'(iter_count), 32'd0);
        wait_until(s + 49);
        chk("iter_first_wrap", 32'(iter_count), 32'd1);
        wait_until(s + 150);
        chk("iter_at_halt", 32'(iter_count), 32'd3);
        halt_run();
        chk("iter_held", 32'(iter_count), 32'd3);
        step();
        chk("stop_one_cycle", 32'(stop_ctrl), 32'd0);

        // replay of the retained table clears iter_count
        go_cycle(IP, 1'b1, t);
        chk("replay_iter_reset", 32'(iter_count), 32'd0);
        wait_until(t + IP + SG + 1 + 5);
        halt_run();

        // abort in load cycle 10
        go_cycle(10, 1'b0, t);
        wait_until(t + 10);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("abort_load_low", 32'(load_ctrl), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(S_FULL));
        repeat (60) step();

        // full reload after abort
        go_cycle(IP, 1'b1, t);
        wait_until(t + IP + SG + 3);
        halt_run();

        // abort during the start gap
        go_cycle(IP, 1'b0, t);
        wait_until(t + IP + 1);
        chk("gap_state", 32'(dbg_state), 32'(S_GAP));
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("gap_abort_busy", 32'(busy), 32'd0);
        repeat (10) step();

        // go together with clear: clear wins
        go = 1'b1;
        clear = 1'b1;
        step();
        go = 1'b0;
        clear = 1'b0;
        chk("clear_go_state", 32'(dbg_state), 32'(S_FILL));
        chk("clear_go_ready", 32'(row_ready), 32'd1);
        chk("clear_go_busy", 32'(busy), 32'd0);
        repeat (5) step();

        // backpressured fill must land from index 0 in order
        fill_rows(1'b1, 24'h0A0B00, 24'h010203);
        go_cycle(IP, 1'b1, t);
        wait_until(t + IP + SG + 4);
        halt_run();

        // reset mid-LOAD
        go_cycle(5, 1'b0, t);
        wait_until(t + 6);
        rst = 1'b1;
        #1;
        chk("rst_load_low", 32'(load_ctrl), 32'd0);
        chk("rst_load_ctrl_in", 32'(ctrl_in), 32'd0);
        chk("rst_load_busy", 32'(busy), 32'd0);
        chk("rst_load_ready", 32'(row_ready), 32'd1);
        step();
        rst = 1'b0;
        go_cycle(0, 1'b0, t);
        repeat (10) step();
        chk("post_rst_go_ignored", 32'(dbg_state), 32'(S_FILL));
        chk("post_rst_busy", 32'(busy), 32'd0);

        // reset mid-RUN
        fill_rows(1'b0, 24'hFFFF00, 24'd1);
        go_cycle(IP, 1'b1, t);
        s = t + IP + SG + 1;
        wait_until(s + 60);
        chk("iter_before_rst", 32'(iter_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_run_running", 32'(running), 32'd0);
        chk("rst_run_iter", 32'(iter_count), 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd0);
        chk("rst_run_ready", 32'(row_ready), 32'd1);
        step();
        rst = 1'b0;
        go_cycle(0, 1'b0, t);
        repeat (10) step();
        chk("post_rst_run_state", 32'(dbg_state), 32'(S_FILL));
        chk("post_rst_run_running", 32'(running), 32'd0);

        repeat (3) step();
        chk("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
